// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one combinational ALU between NREQ requesters.
// Operands are held in registers for SETTLE cycles, then the ALU result is captured and returned.
module alu_arbiter #(
   parameter int  NREQ   = 4,
   parameter int  WIDTH  = 64,
   parameter int  SETTLE = 1,
   localparam int IDW    = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*5-1:0]     req_cmd,
   input  logic [NREQ*7-1:0]     req_opm,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_out,
   output logic [WIDTH-1:0]      rsp_flags,
   output logic                  rsp_err,
   output logic                  busy,
   output logic [4:0]            alu_cmd,
   output logic [6:0]            alu_opm,
   output logic [WIDTH-1:0]      alu_a,
   output logic [WIDTH-1:0]      alu_b,
   input  logic [WIDTH-1:0]      alu_out,
   input  logic [WIDTH-1:0]      alu_regF,
   input  logic [WIDTH-1:0]      alu_error
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [IDW-1:0]   r_ptr;
   logic [3:0]       r_cnt;
   logic [IDW-1:0]   r_rsp_id;
   logic [WIDTH-1:0] r_rsp_out;
   logic [WIDTH-1:0] r_rsp_flags;
   logic             r_rsp_err;
   logic [4:0]       r_alu_cmd;
   logic [6:0]       r_alu_opm;
   logic [WIDTH-1:0] r_alu_a;
   logic [WIDTH-1:0] r_alu_b;

   logic [IDW:0]     w_pick;
   logic             w_any;
   logic [IDW-1:0]   w_win;
   logic [IDW-1:0]   w_ptr_nxt;
   logic             w_xfer;

   // Scanning from the far end lets the requester closest to the pointer overwrite the rest.
   function automatic logic [IDW:0] f_pick(input logic [NREQ-1:0] valid,
                                           input logic [IDW-1:0]  ptr);
      logic [IDW:0] sum;
      logic [IDW:0] res;
      res = '0;
      for (int k = NREQ-1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IDW+1)'(k);
         if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
         if (valid[sum[IDW-1:0]]) res = {1'b1, sum[IDW-1:0]};
      end
      return res;
   endfunction

   assign w_pick    = f_pick(req_valid, r_ptr);
   assign w_any     = w_pick[IDW];
   assign w_win     = w_pick[IDW-1:0];
   assign w_ptr_nxt = (w_win == IDW'(NREQ-1)) ? '0 : w_win + 1'b1;
   assign w_xfer    = (r_state == S_IDLE) && w_any;
   assign req_ready = w_xfer ? (NREQ'(1) << w_win) : '0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_xfer) w_state_nxt = S_ISSUE;
         S_ISSUE: if (r_cnt == 4'd0) w_state_nxt = S_RESP;
         S_RESP:  if (rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ALU input registers only move on a grant, so the ALU's flag state is left undisturbed.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_ptr       <= '0;
         r_cnt       <= '0;
         r_rsp_id    <= '0;
         r_rsp_out   <= '0;
         r_rsp_flags <= '0;
         r_rsp_err   <= 1'b0;
         r_alu_cmd   <= 5'b11111;
         r_alu_opm   <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               if (w_xfer) begin
                  r_alu_cmd <= req_cmd[5*int'(w_win) +: 5];
                  r_alu_opm <= req_opm[7*int'(w_win) +: 7];
                  r_alu_a   <= req_a[WIDTH*int'(w_win) +: WIDTH];
                  r_alu_b   <= req_b[WIDTH*int'(w_win) +: WIDTH];
                  r_rsp_id  <= w_win;
                  r_ptr     <= w_ptr_nxt;
                  r_cnt     <= 4'(SETTLE-1);
               end
            end
            S_ISSUE: begin
               if (r_cnt == 4'd0) begin
                  r_rsp_out   <= alu_out;
                  r_rsp_flags <= alu_regF;
                  r_rsp_err   <= |alu_error;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid = (r_state == S_RESP);
   assign busy      = (r_state != S_IDLE);
   assign rsp_id    = r_rsp_id;
   assign rsp_out   = r_rsp_out;
   assign rsp_flags = r_rsp_flags;
   assign rsp_err   = r_rsp_err;
   assign alu_cmd   = r_alu_cmd;
   assign alu_opm   = r_alu_opm;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;

endmodule
